// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit: radix-2 shift-add multiply and restoring divide.
// One iteration per cycle; divide-by-zero and signed overflow retire without iterating.
module ex_muldiv #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wen_o,
  output logic            busy_o,
  output logic            hold_flag_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [4:0]          rd_addr_q, rd_addr_d;
  logic                neg_q, neg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;

  op_e                 op_in;
  logic                sgn1_en, sgn2_en, neg1, neg2;
  logic [XLEN-1:0]     mag1, mag2;
  logic                div_zero, div_ovf;

  always_comb begin
    op_in    = op_e'(op_i);
    sgn1_en  = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
               (op_in == OP_DIV)  || (op_in == OP_REM);
    sgn2_en  = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    neg1     = sgn1_en & op1_i[XLEN-1];
    neg2     = sgn2_en & op2_i[XLEN-1];
    mag1     = neg1 ? ('0 - op1_i) : op1_i;
    mag2     = neg2 ? ('0 - op2_i) : op2_i;
    div_zero = op_i[2] && (op2_i == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (op1_i == MIN_NEG) && (op2_i == '1);
  end

  // Iteration datapaths: acc holds {hi, lo} = {product hi, multiplier} or {rem, quot}.
  logic [XLEN-1:0]   acc_hi, acc_lo;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next;
  logic [XLEN:0]     rem_ext;
  logic              div_ge;
  logic [XLEN-1:0]   rem_sub, rem_new;

  always_comb begin
    acc_hi   = acc_q[2*XLEN-1:XLEN];
    acc_lo   = acc_q[XLEN-1:0];
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_lo[XLEN-1:1]};
    // Remainder after the shift needs one extra bit; the low XLEN bits of the difference are exact.
    rem_ext  = acc_q[2*XLEN-1:XLEN-1];
    div_ge   = rem_ext >= {1'b0, opb_q};
    rem_sub  = rem_ext[XLEN-1:0] - opb_q;
    rem_new  = div_ge ? rem_sub : rem_ext[XLEN-1:0];
    div_next = {rem_new, acc_lo[XLEN-2:0], div_ge};
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_addr_d = rd_addr_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          op_d      = op_in;
          rd_addr_d = rd_addr_i;
          if (div_zero) begin
            acc_d   = {op1_i, {XLEN{1'b1}}};
            neg_d   = 1'b0;
            state_d = S_DONE;
          end else if (div_ovf) begin
            acc_d   = {{XLEN{1'b0}}, op1_i};
            neg_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            neg_d   = (op_in == OP_REM) ? neg1 : (neg1 ^ neg2);
            acc_d   = {{XLEN{1'b0}}, (op_i[2] ? mag1 : mag2)};
            opb_d   = op_i[2] ? mag2 : mag1;
            cnt_d   = CNT_W'(XLEN);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      rd_addr_q <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_addr_q <= rd_addr_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   result;

  always_comb begin
    prod = neg_q ? ('0 - acc_q) : acc_q;
    unique case (op_q)
      OP_MUL:                       result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = neg_q ? ('0 - acc_lo) : acc_lo;
      OP_REM, OP_REMU:              result = neg_q ? ('0 - acc_hi) : acc_hi;
      default:                      result = '0;
    endcase
  end

  always_comb begin
    rd_wen_o    = (state_q == S_DONE) && !flush_i;
    rd_data_o   = (state_q == S_DONE) ? result : '0;
    rd_addr_o   = rd_addr_q;
    busy_o      = (state_q != S_IDLE);
    hold_flag_o = ((state_q == S_IDLE) && start_i && !flush_i) || (state_q == S_CALC);
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: results, latency, hold, flush and reset behaviour.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] op1_i = '0;
  logic [31:0] op2_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wen_o;
  logic        busy_o;
  logic        hold_flag_o;

  int checks = 0;
  int errors = 0;
  int wen_pulses = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .rd_addr_i   (rd_addr_i),
    .flush_i     (flush_i),
    .rd_data_o   (rd_data_o),
    .rd_addr_o   (rd_addr_o),
    .rd_wen_o    (rd_wen_o),
    .busy_o      (busy_o),
    .hold_flag_o (hold_flag_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rd_wen_o) wen_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op and follow it to write-back; latency counted in cycles after the accepting edge.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_lat, input bit flush_at_done);
    int lat;
    int hold_cnt;
    @(negedge clk);
    start_i = 1'b1; op_i = op; op1_i = a; op2_i = b; rd_addr_i = rd;
    #1 check({tag, " hold@0"}, 32'(hold_flag_o), 32'd1);
    @(negedge clk);
    start_i = 1'b0;
    lat = 1;
    hold_cnt = 0;
    while (!rd_wen_o && lat < 40) begin
      if (hold_flag_o) hold_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, " wen"}, 32'(rd_wen_o), 32'd1);
    check({tag, " lat"}, 32'(lat), 32'(exp_lat));
    check({tag, " holdcyc"}, 32'(hold_cnt), 32'(exp_lat - 1));
    check({tag, " hold@done"}, 32'(hold_flag_o), 32'd0);
    if (flush_at_done) begin
      flush_i = 1'b1;
      #1 check({tag, " wen flushed"}, 32'(rd_wen_o), 32'd0);
      @(negedge clk);
      flush_i = 1'b0;
      check({tag, " idle after flush"}, 32'(busy_o), 32'd0);
    end else begin
      check({tag, " data"}, rd_data_o, exp);
      check({tag, " rd"}, 32'(rd_addr_o), 32'(rd));
    end
  endtask

  initial begin
    int snap;
    #3;
    check("reset wen", 32'(rd_wen_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset hold", 32'(hold_flag_o), 32'd0);
    check("reset data", rd_data_o, 32'd0);
    check("reset rd", 32'(rd_addr_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op("MUL",     3'b000, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33, 1'b0);
    do_op("MULH",    3'b001, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 33, 1'b0);
    do_op("MULHU",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 33, 1'b0);
    do_op("MULHSU",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 33, 1'b0);
    do_op("DIV",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 33, 1'b0);
    do_op("REM",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33, 1'b0);
    do_op("DIVU",    3'b101, 32'd100,      32'd7,        5'd7,  32'd14,       33, 1'b0);
    do_op("REMU",    3'b111, 32'd100,      32'd7,        5'd8,  32'd2,        33, 1'b0);
    do_op("DIVneg2", 3'b100, 32'd20,       32'hFFFFFFFD, 5'd9,  32'hFFFFFFFA, 33, 1'b0);
    do_op("REMneg2", 3'b110, 32'd20,       32'hFFFFFFFD, 5'd10, 32'd2,        33, 1'b0);
    do_op("MULrd0",  3'b000, 32'd12345,    32'd1000,     5'd0,  32'd12345000, 33, 1'b0);
    do_op("DIVU/0",  3'b101, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1,  1'b0);
    do_op("REM/0",   3'b110, 32'd5,        32'd0,        5'd12, 32'd5,        1,  1'b0);
    do_op("DIVovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1,  1'b0);
    do_op("REMovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        1,  1'b0);
    do_op("MULflushD", 3'b000, 32'd3,      32'd4,        5'd15, 32'd12,       33, 1'b1);

    // start together with flush in IDLE
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'b000; op1_i = 32'd2; op2_i = 32'd2;
    #1 check("startflush hold", 32'(hold_flag_o), 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check("startflush busy", 32'(busy_o), 32'd0);

    // flush at cycle 10 of CALC, with a start issued mid-CALC
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b100; op1_i = 32'd1000; op2_i = 32'd7; rd_addr_i = 5'd20;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    start_i = 1'b1; op_i = 3'b000; op1_i = 32'd9; op2_i = 32'd9;
    #1 check("calc start hold", 32'(hold_flag_o), 32'd1);
    check("calc start busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    snap = wen_pulses;
    flush_i = 1'b1;
    #1 check("calc flush wen", 32'(rd_wen_o), 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    check("calc flush busy", 32'(busy_o), 32'd0);
    repeat (40) @(negedge clk);
    check("calc flush pulses", 32'(wen_pulses), 32'(snap));
    do_op("DIVUafterflush", 3'b101, 32'd1000, 32'd7, 5'd21, 32'd142, 33, 1'b0);

    // asynchronous reset at cycle 20 of a DIV
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b100; op1_i = 32'd1000; op2_i = 32'd3; rd_addr_i = 5'd22;
    @(negedge clk);
    start_i = 1'b0;
    repeat (19) @(negedge clk);
    snap = wen_pulses;
    #2 rst = 1'b0;
    #1;
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst hold", 32'(hold_flag_o), 32'd0);
    check("rst wen", 32'(rd_wen_o), 32'd0);
    check("rst data", rd_data_o, 32'd0);
    check("rst rd", 32'(rd_addr_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("rst pulses", 32'(wen_pulses), 32'(snap));

    // back-to-back: second start lands in the cycle after DONE
    do_op("B2B1", 3'b001, 32'hFFFFFFFE, 32'd3,        5'd23, 32'hFFFFFFFF, 33, 1'b0);
    do_op("B2B2", 3'b111, 32'hFFFFFFFF, 32'h00010000, 5'd24, 32'h0000FFFF, 33, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
